iterative_alu: RTL and testbench

ITERATIVE_ALU -- requirements
Module: iterative_alu

---
 rtl/ALU_pkg.sv | 35 +++
 rtl/mdu_core.sv | 92 +++++++++
 rtl/iterative_alu.sv | 145 ++++++++++++++
 tb/tb_iterative_alu.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ALU_pkg.sv
// Opcode constants and FSM state encoding shared by iterative_alu and mdu_core.
package ALU_pkg;

  localparam logic [5:0] ALU_ADD    = 6'd0;
  localparam logic [5:0] ALU_SUB    = 6'd1;
  localparam logic [5:0] ALU_AND    = 6'd2;
  localparam logic [5:0] ALU_OR     = 6'd3;
  localparam logic [5:0] ALU_XOR    = 6'd4;
  localparam logic [5:0] ALU_SLT    = 6'd5;
  localparam logic [5:0] ALU_SLTU   = 6'd6;
  localparam logic [5:0] ALU_SLL    = 6'd7;
  localparam logic [5:0] ALU_SRL    = 6'd8;
  localparam logic [5:0] ALU_SRA    = 6'd9;
  localparam logic [5:0] ALU_BEQ    = 6'd10;
  localparam logic [5:0] ALU_BNE    = 6'd11;
  localparam logic [5:0] ALU_BLT    = 6'd12;
  localparam logic [5:0] ALU_BGE    = 6'd13;
  localparam logic [5:0] ALU_BGEU   = 6'd14;
  localparam logic [5:0] ALU_BLTU   = 6'd15;
  localparam logic [5:0] ALU_MUL    = 6'd16;
  localparam logic [5:0] ALU_MULH   = 6'd17;
  localparam logic [5:0] ALU_MULHSU = 6'd18;
  localparam logic [5:0] ALU_MULHU  = 6'd19;
  localparam logic [5:0] ALU_DIV    = 6'd20;
  localparam logic [5:0] ALU_DIVU   = 6'd21;
  localparam logic [5:0] ALU_REM    = 6'd22;
  localparam logic [5:0] ALU_REMU   = 6'd23;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mdu_core.sv
// Radix-2 iterative unit: shift-add multiplier and restoring divider sharing one
// hi/lo register pair; operates on magnitudes and fixes signs on the way out.
module mdu_core import ALU_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            run,
  input  logic [5:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            last,
  output logic [XLEN-1:0] res
);
  localparam int CW = $clog2(XLEN);

  logic [CW-1:0]     cnt_reg;
  logic [XLEN-1:0]   hi_reg, lo_reg, mcand_reg;
  logic              is_mul_reg, is_hi_reg, is_rem_reg, neg_q_reg, neg_r_reg;
  logic [XLEN-1:0]   hi_next, lo_next;
  logic              signed_a, signed_b, sa, sb, is_mul;
  logic [XLEN-1:0]   ma, mb;
  logic [XLEN:0]     sum, tmp, diff;
  logic [2*XLEN-1:0] prod;

  always_comb begin
    signed_a = (op == ALU_MULH) || (op == ALU_MULHSU) || (op == ALU_DIV) || (op == ALU_REM);
    signed_b = (op == ALU_MULH) || (op == ALU_DIV) || (op == ALU_REM);
    is_mul   = (op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_MULHSU) || (op == ALU_MULHU);
    sa       = signed_a && a[XLEN-1];
    sb       = signed_b && b[XLEN-1];
    ma       = sa ? -a : a;
    mb       = sb ? -b : b;
  end

  // hi holds the partial product / partial remainder, lo the multiplier / quotient bits
  always_comb begin
    sum  = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, mcand_reg} : '0);
    tmp  = {hi_reg, lo_reg[XLEN-1]};
    diff = tmp - {1'b0, mcand_reg};
    if (is_mul_reg) begin
      hi_next = sum[XLEN:1];
      lo_next = {sum[0], lo_reg[XLEN-1:1]};
    end else if (!diff[XLEN]) begin
      hi_next = diff[XLEN-1:0];
      lo_next = {lo_reg[XLEN-2:0], 1'b1};
    end else begin
      hi_next = tmp[XLEN-1:0];
      lo_next = {lo_reg[XLEN-2:0], 1'b0};
    end
  end

  always_comb begin
    prod = {hi_next, lo_next};
    if (neg_q_reg) prod = -prod;
    if (is_mul_reg)      res = is_hi_reg ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    else if (is_rem_reg) res = neg_r_reg ? -hi_next : hi_next;
    else                 res = neg_q_reg ? -lo_next : lo_next;
  end

  assign last = (cnt_reg == CW'(XLEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg    <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      mcand_reg  <= '0;
      is_mul_reg <= 1'b0;
      is_hi_reg  <= 1'b0;
      is_rem_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
    end else if (start) begin
      cnt_reg    <= '0;
      hi_reg     <= '0;
      lo_reg     <= is_mul ? mb : ma;
      mcand_reg  <= is_mul ? ma : mb;
      is_mul_reg <= is_mul;
      is_hi_reg  <= (op == ALU_MULH) || (op == ALU_MULHSU) || (op == ALU_MULHU);
      is_rem_reg <= (op == ALU_REM) || (op == ALU_REMU);
      neg_q_reg  <= sa ^ sb;
      neg_r_reg  <= sa;
    end else if (run) begin
      cnt_reg <= cnt_reg + 1'b1;
      hi_reg  <= hi_next;
      lo_reg  <= lo_next;
    end
  end

endmodule

// File: rtl/iterative_alu.sv
// Handshaked ALU: single-cycle base/branch ops, iterative M ops when built with
// ALU_MDU_EN (otherwise M opcodes complete as illegal).
module iterative_alu import ALU_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [5:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);
  localparam int SHW = $clog2(XLEN);

  state_t          state_reg, state_next;
  logic [XLEN-1:0] result_reg, result_next;
  logic            illegal_reg, illegal_next;
  logic [XLEN-1:0] imm_res;
  logic            imm_legal;
  logic [SHW-1:0]  shamt;

  assign shamt = b[SHW-1:0];

`ifdef ALU_MDU_EN
  logic            go_busy, mdu_start, mdu_run, mdu_last;
  logic [XLEN-1:0] mdu_res;
`endif

  always_comb begin
    imm_res   = '0;
    imm_legal = 1'b1;
    case (op)
      ALU_ADD:  imm_res = a + b;
      ALU_SUB:  imm_res = a - b;
      ALU_AND:  imm_res = a & b;
      ALU_OR:   imm_res = a | b;
      ALU_XOR:  imm_res = a ^ b;
      ALU_SLT:  imm_res[0] = $signed(a) < $signed(b);
      ALU_SLTU: imm_res[0] = a < b;
      ALU_SLL:  imm_res = a << shamt;
      ALU_SRL:  imm_res = a >> shamt;
      ALU_SRA:  imm_res = $unsigned($signed(a) >>> shamt);
      ALU_BEQ:  imm_res[0] = a == b;
      ALU_BNE:  imm_res[0] = a != b;
      ALU_BLT:  imm_res[0] = $signed(a) < $signed(b);
      ALU_BGE:  imm_res[0] = !($signed(a) < $signed(b));
      ALU_BLTU: imm_res[0] = a < b;
      ALU_BGEU: imm_res[0] = !(a < b);
      default:  imm_legal = 1'b0;
    endcase
`ifdef ALU_MDU_EN
    // Divide-by-zero and signed overflow resolve immediately instead of iterating
    go_busy = 1'b0;
    if (op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                   ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU}) begin
      imm_legal = 1'b1;
      if ((op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU}) && (b == '0))
        imm_res = (op inside {ALU_REM, ALU_REMU}) ? a : '1;
      else if ((op inside {ALU_DIV, ALU_REM}) && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1))
        imm_res = (op == ALU_REM) ? '0 : a;
      else
        go_busy = 1'b1;
    end
`endif
  end

`ifdef ALU_MDU_EN
  assign mdu_run = (state_reg == BUSY);

  mdu_core #(.XLEN(XLEN)) u_mdu (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mdu_start),
    .run   (mdu_run),
    .op    (op),
    .a     (a),
    .b     (b),
    .last  (mdu_last),
    .res   (mdu_res)
  );
`endif

  always_comb begin
    state_next   = state_reg;
    result_next  = result_reg;
    illegal_next = illegal_reg;
`ifdef ALU_MDU_EN
    mdu_start    = 1'b0;
`endif
    if (kill) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: if (in_valid) begin
          state_next   = DONE;
          result_next  = imm_res;
          illegal_next = !imm_legal;
`ifdef ALU_MDU_EN
          if (go_busy) begin
            state_next   = BUSY;
            mdu_start    = 1'b1;
            result_next  = result_reg;
            illegal_next = illegal_reg;
          end
`endif
        end
`ifdef ALU_MDU_EN
        BUSY: if (mdu_last) begin
          state_next   = DONE;
          result_next  = mdu_res;
          illegal_next = 1'b0;
        end
`endif
        DONE:    if (out_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      result_reg  <= '0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      result_reg  <= result_next;
      illegal_reg <= illegal_next;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign result    = result_reg;
  assign zero      = (result_reg == '0);
  assign illegal   = illegal_reg;

endmodule

// File: tb/tb_iterative_alu.sv
// Scoreboard bench for iterative_alu (XLEN=32); M-op expectations follow ALU_MDU_EN.
module tb_iterative_alu;
  import ALU_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, kill, out_ready;
  logic        in_ready, out_valid, zero, illegal;
  logic [5:0]  op;
  logic [31:0] a, b, result;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] res;
    logic        ill;
    int          lat;
    int          acc;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  bit   first_seen = 1'b0;

  iterative_alu #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .kill      (kill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request; the expected response is queued before the accepting edge.
  task automatic issue(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] r, input logic il, input int lat,
                       input string nm, input bit push);
    int   n = 0;
    exp_t e;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL %s_issue_timeout: actual in_ready=0 required in_ready=1", nm);
      return;
    end
    op = o;
    a = x;
    b = y;
    in_valid = 1'b1;
    if (push) begin
      e.res  = r;
      e.ill  = il;
      e.lat  = lat;
      e.acc  = cyc + 1;
      e.name = nm;
      sb_q.push_back(e);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic issue_m(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] r, input int lat, input string nm);
`ifdef ALU_MDU_EN
    issue(o, x, y, r, 1'b0, lat, nm, 1'b1);
`else
    issue(o, x, y, 32'h0, 1'b1, 1, nm, 1'b1);
`endif
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: actual pending=%0d required pending=0", sb_q.size());
      sb_q.delete();
      first_seen = 1'b0;
    end
  endtask

  // Monitor: checks every cycle the DUT presents a response, pops on handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out_valid: actual result=%0h required no response", result);
      end else begin
        if (!first_seen) begin
          check({sb_q[0].name, "_latency"}, 64'(cyc - sb_q[0].acc + 1), 64'(sb_q[0].lat));
          first_seen = 1'b1;
        end
        check({sb_q[0].name, "_result"}, 64'(result), 64'(sb_q[0].res));
        check({sb_q[0].name, "_zero"}, 64'(zero), 64'(sb_q[0].res == 32'h0));
        check({sb_q[0].name, "_illegal"}, 64'(illegal), 64'(sb_q[0].ill));
        check({sb_q[0].name, "_in_ready_done"}, 64'(in_ready), 64'd0);
        if (out_ready) begin
          $display("txn %s result=%h zero=%b illegal=%b", sb_q[0].name, result, zero, illegal);
          void'(sb_q.pop_front());
          first_seen = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual still running required finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    in_valid = 1'b0; kill = 1'b0; out_ready = 1'b1;
    op = 6'd0; a = 32'h0; b = 32'h0; rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_zero", 64'(zero), 64'd1);
    check("rst_illegal", 64'(illegal), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    issue(ALU_ADD,  32'd1,        32'd1,        32'd2,        1'b0, 1, "add_1_1", 1'b1);
    issue(ALU_SUB,  32'd5,        32'd5,        32'd0,        1'b0, 1, "sub_eq", 1'b1);
    issue(ALU_SUB,  32'd3,        32'd5,        32'hFFFFFFFE, 1'b0, 1, "sub_neg", 1'b1);
    issue(ALU_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1, "and", 1'b1);
    issue(ALU_OR,   32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 1'b0, 1, "or", 1'b1);
    issue(ALU_XOR,  32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1'b0, 1, "xor", 1'b1);
    issue(ALU_SLT,  32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1, "slt", 1'b1);
    issue(ALU_SLTU, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 1, "sltu", 1'b1);
    issue(ALU_SLL,  32'd1,        32'd35,       32'd8,        1'b0, 1, "sll_wrap", 1'b1);
    issue(ALU_SLL,  32'd1,        32'd31,       32'h80000000, 1'b0, 1, "sll_31", 1'b1);
    issue(ALU_SRL,  32'h80000000, 32'd4,        32'h08000000, 1'b0, 1, "srl", 1'b1);
    issue(ALU_SRA,  32'hFFFFFFF8, 32'd34,       32'hFFFFFFFE, 1'b0, 1, "sra_m8_34", 1'b1);
    issue(ALU_BNE,  32'd50,       32'd50,       32'd0,        1'b0, 1, "bne", 1'b1);
    issue(ALU_BLT,  32'hFFFFFFFB, 32'd3,        32'd1,        1'b0, 1, "blt", 1'b1);
    issue(ALU_BGE,  32'hFFFFFFFB, 32'd3,        32'd0,        1'b0, 1, "bge", 1'b1);
    issue(ALU_BLTU, 32'hFFFFFFFB, 32'd3,        32'd0,        1'b0, 1, "bltu", 1'b1);
    issue(ALU_BGEU, 32'hFFFFFFFB, 32'd3,        32'd1,        1'b0, 1, "bgeu", 1'b1);
    issue(6'h3F,    32'd9,        32'd9,        32'd0,        1'b1, 1, "unknown_op", 1'b1);
    drain();

    // BEQ held in DONE while out_ready stays low for 5 cycles
    out_ready = 1'b0;
    issue(ALU_BEQ, 32'd50, 32'd50, 32'd1, 1'b0, 1, "beq_hold", 1'b1);
    repeat (4) tick();
    out_ready = 1'b1;
    drain();

    issue_m(ALU_MULH, 32'h80000000, 32'd2, 32'hFFFFFFFF, 33, "mulh");
`ifdef ALU_MDU_EN
    for (int i = 0; i < 32; i++) begin
      check("mulh_in_ready_busy", 64'(in_ready), 64'd0);
      tick();
    end
`endif
    drain();
    issue_m(ALU_MUL,    32'd7,        32'd6,        32'd42,       33, "mul");
    issue_m(ALU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, "mulhu");
    issue_m(ALU_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33, "mulhsu");
    issue_m(ALU_DIV,    32'd7,        32'd0,        32'hFFFFFFFF, 1,  "div_by_zero");
    issue_m(ALU_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  "rem_ovf");
    issue_m(ALU_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  "div_ovf");
    issue_m(ALU_REMU,   32'd9,        32'd0,        32'd9,        1,  "remu_by_zero");
    issue_m(ALU_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, "div_neg");
    issue_m(ALU_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, "rem_neg");
    issue_m(ALU_REMU,   32'd100,      32'd7,        32'd2,        33, "remu");
    drain();

    // DIVU aborted by kill ten cycles after acceptance
`ifdef ALU_MDU_EN
    issue(ALU_DIVU, 32'd100, 32'd7, 32'd0, 1'b0, 0, "divu_killed", 1'b0);
`else
    issue(ALU_DIVU, 32'd100, 32'd7, 32'd0, 1'b1, 1, "divu_killed", 1'b1);
`endif
    repeat (9) tick();
    kill = 1'b1;
    tick();
    kill = 1'b0;
    check("kill_in_ready", 64'(in_ready), 64'd1);
    check("kill_out_valid", 64'(out_valid), 64'd0);
    repeat (40) tick();
    issue_m(ALU_DIVU, 32'd100, 32'd7, 32'd14, 33, "divu_after_kill");
    drain();

    // kill on the same edge as in_valid drops the request
    op = ALU_ADD; a = 32'd3; b = 32'd4;
    in_valid = 1'b1;
    kill = 1'b1;
    tick();
    in_valid = 1'b0;
    kill = 1'b0;
    check("kill_drop_in_ready", 64'(in_ready), 64'd1);
    check("kill_drop_out_valid", 64'(out_valid), 64'd0);
    repeat (3) tick();

    // asynchronous reset, mid-operation when the MDU is present
    issue(ALU_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1, "add_pre_rst", 1'b1);
    drain();
`ifdef ALU_MDU_EN
    issue(ALU_MUL, 32'd7, 32'd6, 32'd0, 1'b0, 0, "mul_reset", 1'b0);
    repeat (5) tick();
`endif
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_in_ready", 64'(in_ready), 64'd1);
    check("rst_mid_out_valid", 64'(out_valid), 64'd0);
    check("rst_mid_result", 64'(result), 64'd0);
    check("rst_mid_zero", 64'(zero), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) tick();
    issue(ALU_ADD, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b0, 1, "add_post_rst", 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
